mp_mac_accumulator: RTL and testbench

Sequential accumulate stage directly downstream of the four 4x4 partial-product multipliers in the multiprecision MAC datapath. Each beat carries four 8-bit products. In QUAD mode they are four independent 4-bit lanes. In OCTO mode they are recombined into one 16-bit 8x8 product. Lane sums are accumulated across a dot-product sequence, and the result is presented on a valid/ready output to the CORDIC activation engine.

---
 rtl/mp_mac_accumulator.sv | 144 ++++++++++++++
 tb/tb_mp_mac_accumulator.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mp_mac_accumulator.sv
// Accumulates four 8-bit partial products per beat (QUAD lanes, or one recombined 8x8 lane in OCTO).
// Latency: a last beat accepted at edge E presents its result (out_valid) after edge E+2.
// Backpressure: in_ready is low in FLUSH/HOLD; the result is held until out_ready, then the lanes clear.
module mp_mac_accumulator #(
    parameter int ACC_W = 24
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 mode,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic                 in_last,
    input  logic [7:0]           pp0,
    input  logic [7:0]           pp1,
    input  logic [7:0]           pp2,
    input  logic [7:0]           pp3,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [4*ACC_W-1:0]   out_acc,
    output logic                 out_mode,
    output logic [3:0]           out_ovf
);

    typedef enum logic [1:0] {RUN, FLUSH, HOLD} state_t;

    state_t          state;
    logic            seq_active;
    logic            mode_q;
    logic            eff_mode;
    logic            accept;
    logic            release_hold;
    logic [15:0]     p_d   [4];
    logic [15:0]     p_q   [4];
    logic            s1_vld;
    logic            s1_last;
    logic [ACC_W-1:0] acc  [4];
    logic [ACC_W:0]  sum   [4];
    logic [3:0]      ovf;

    assign in_ready     = (state == RUN);
    assign accept       = in_valid & in_ready;
    // Mode is only sampled on the opening beat; later beats reuse the latched value.
    assign eff_mode     = seq_active ? mode_q : mode;
    assign release_hold = (state == HOLD) & out_valid & out_ready;
    assign out_mode     = mode_q;
    assign out_ovf      = ovf;

    // Stage-1 operand formation: zero-extend lanes, or recombine the four 4x4 products into 8x8.
    always_comb begin
        for (int i = 0; i < 4; i++) p_d[i] = 16'd0;
        if (eff_mode) begin
            p_d[0] = {8'd0, pp0} + {4'd0, pp1, 4'd0} + {4'd0, pp2, 4'd0} + {pp3, 8'd0};
        end else begin
            p_d[0] = {8'd0, pp0};
            p_d[1] = {8'd0, pp1};
            p_d[2] = {8'd0, pp2};
            p_d[3] = {8'd0, pp3};
        end
    end

    // Stage-2 adders, one bit wider than the accumulator so the carry-out flags saturation.
    always_comb begin
        for (int i = 0; i < 4; i++)
            sum[i] = {1'b0, acc[i]} + {{(ACC_W-15){1'b0}}, p_q[i]};
    end

    // Lane view of the accumulator registers.
    always_comb begin
        out_acc = '0;
        for (int i = 0; i < 4; i++) out_acc[i*ACC_W +: ACC_W] = acc[i];
    end

    // Stage-1 pipeline register, loaded on every accepted beat.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_vld  <= 1'b0;
            s1_last <= 1'b0;
            for (int i = 0; i < 4; i++) p_q[i] <= 16'd0;
        end else begin
            s1_vld  <= accept;
            s1_last <= accept & in_last;
            if (accept) begin
                for (int i = 0; i < 4; i++) p_q[i] <= p_d[i];
            end
        end
    end

    // Stage-2 saturating accumulate with sticky per-lane overflow; cleared when the result is taken.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ovf <= 4'd0;
            for (int i = 0; i < 4; i++) acc[i] <= '0;
        end else if (release_hold) begin
            ovf <= 4'd0;
            for (int i = 0; i < 4; i++) acc[i] <= '0;
        end else if (s1_vld) begin
            for (int i = 0; i < 4; i++) begin
                if (sum[i][ACC_W]) begin
                    acc[i] <= {ACC_W{1'b1}};
                    ovf[i] <= 1'b1;
                end else begin
                    acc[i] <= sum[i][ACC_W-1:0];
                end
            end
        end
    end

    // Sequence control: RUN takes beats, FLUSH drains stage 2, HOLD presents the result.
    // out_valid rises one cycle into HOLD so the presented lanes have a full settled cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= RUN;
            seq_active <= 1'b0;
            mode_q     <= 1'b0;
            out_valid  <= 1'b0;
        end else begin
            case (state)
                RUN: begin
                    if (accept) begin
                        if (!seq_active) begin
                            seq_active <= 1'b1;
                            mode_q     <= mode;
                        end
                        if (in_last) state <= FLUSH;
                    end
                end
                FLUSH: begin
                    if (s1_last) state <= HOLD;
                end
                HOLD: begin
                    if (!out_valid) begin
                        out_valid <= 1'b1;
                    end else if (out_ready) begin
                        out_valid  <= 1'b0;
                        seq_active <= 1'b0;
                        state      <= RUN;
                    end
                end
                default: state <= RUN;
            endcase
        end
    end

endmodule

// File: tb/tb_mp_mac_accumulator.sv
module tb_mp_mac_accumulator;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        mode = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_last = 1'b0;
    logic [7:0]  pp0 = 8'd0, pp1 = 8'd0, pp2 = 8'd0, pp3 = 8'd0;
    logic        out_ready = 1'b0;

    logic        rdy24, ov24, om24;
    logic [95:0] acc24;
    logic [3:0]  ovf24;
    logic        rdy16, ov16, om16;
    logic [63:0] acc16;
    logic [3:0]  ovf16;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [95:0] acc24;
        logic [63:0] acc16;
        logic        mode;
        logic [3:0]  ovf24;
        logic [3:0]  ovf16;
    } exp_t;
    exp_t q[$];

    // reference model state
    longint m_acc24[4];
    longint m_acc16[4];
    logic [3:0] m_ovf24, m_ovf16;
    logic m_act, m_mode;

    mp_mac_accumulator #(.ACC_W(24)) dut24 (
        .clk(clk), .rst(rst), .mode(mode), .in_valid(in_valid), .in_ready(rdy24),
        .in_last(in_last), .pp0(pp0), .pp1(pp1), .pp2(pp2), .pp3(pp3),
        .out_valid(ov24), .out_ready(out_ready), .out_acc(acc24), .out_mode(om24), .out_ovf(ovf24)
    );

    mp_mac_accumulator #(.ACC_W(16)) dut16 (
        .clk(clk), .rst(rst), .mode(mode), .in_valid(in_valid), .in_ready(rdy16),
        .in_last(in_last), .pp0(pp0), .pp1(pp1), .pp2(pp2), .pp3(pp3),
        .out_valid(ov16), .out_ready(out_ready), .out_acc(acc16), .out_mode(om16), .out_ovf(ovf16)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL global_timeout");
        $fatal(1, "global timeout");
    end

    task automatic chk(input string name, input logic [95:0] act, input logic [95:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < 4; i++) begin
            m_acc24[i] = 0;
            m_acc16[i] = 0;
        end
        m_ovf24 = 4'd0;
        m_ovf16 = 4'd0;
        m_act   = 1'b0;
        m_mode  = 1'b0;
    endtask

    // Drive one beat (called at posedge+2); returns at posedge+2 after the accepting edge.
    task automatic send(input logic m, input logic last,
                        input int a, input int b, input int c, input int d);
        int n;
        logic eff;
        longint p[4];
        exp_t e;
        mode = m; in_last = last; in_valid = 1'b1;
        pp0 = 8'(a); pp1 = 8'(b); pp2 = 8'(c); pp3 = 8'(d);
        n = 0;
        while (!rdy24 && n < 20) begin
            @(posedge clk); #2;
            n++;
        end
        if (!rdy24) chk("send_ready_timeout", 96'(rdy24), 96'd1);
        @(posedge clk); #2;
        in_valid = 1'b0;
        in_last  = 1'b0;
        eff = m_act ? m_mode : m;
        if (!m_act) begin
            m_act  = 1'b1;
            m_mode = m;
        end
        if (eff) begin
            p[0] = longint'(a) + longint'(b) * 16 + longint'(c) * 16 + longint'(d) * 256;
            p[1] = 0; p[2] = 0; p[3] = 0;
        end else begin
            p[0] = a; p[1] = b; p[2] = c; p[3] = d;
        end
        for (int i = 0; i < 4; i++) begin
            m_acc24[i] += p[i];
            if (m_acc24[i] > 64'hFFFFFF) begin m_acc24[i] = 64'hFFFFFF; m_ovf24[i] = 1'b1; end
            m_acc16[i] += p[i];
            if (m_acc16[i] > 64'hFFFF) begin m_acc16[i] = 64'hFFFF; m_ovf16[i] = 1'b1; end
        end
        if (last) begin
            for (int i = 0; i < 4; i++) begin
                e.acc24[i*24 +: 24] = m_acc24[i][23:0];
                e.acc16[i*16 +: 16] = m_acc16[i][15:0];
            end
            e.mode  = m_mode;
            e.ovf24 = m_ovf24;
            e.ovf16 = m_ovf16;
            q.push_back(e);
            model_clear();
        end
    endtask

    task automatic wait_valid();
        int n = 0;
        while (!ov24 && n < 10) begin
            @(posedge clk); #2;
            n++;
        end
        chk("wait_out_valid", 96'(ov24), 96'd1);
    endtask

    task automatic take_result();
        out_ready = 1'b1;
        @(posedge clk); #2;
        out_ready = 1'b0;
        chk("in_ready_after_take", 96'(rdy24), 96'd1);
    endtask

    // Scoreboard monitor: compares the presented result every cycle it is valid, pops on handshake.
    always @(negedge clk) begin
        if (!rst && ov24) begin
            if (q.size() == 0) begin
                chk("unexpected_output", 96'(ov24), 96'd0);
            end else begin
                chk("acc24", acc24, q[0].acc24);
                chk("mode24", 96'(om24), 96'(q[0].mode));
                chk("ovf24", 96'(ovf24), 96'(q[0].ovf24));
                chk("valid16", 96'(ov16), 96'd1);
                chk("acc16", 96'(acc16), 96'(q[0].acc16));
                chk("ovf16", 96'(ovf16), 96'(q[0].ovf16));
                if (out_ready) void'(q.pop_front());
            end
        end
    end

    initial begin
        model_clear();
        // 1. reset state
        repeat (3) @(posedge clk);
        #2 rst = 1'b0;
        @(posedge clk); #2;
        chk("rst_in_ready", 96'(rdy24), 96'd1);
        chk("rst_out_valid", 96'(ov24), 96'd0);
        chk("rst_out_acc", acc24, 96'd0);
        chk("rst_out_ovf", 96'(ovf24), 96'd0);
        chk("rst_out_mode", 96'(om24), 96'd0);

        // 2. OCTO single beat, 0xFF*0xFF, latency check
        send(1'b1, 1'b1, 8'hE1, 8'hE1, 8'hE1, 8'hE1);
        chk("lat_e0_valid", 96'(ov24), 96'd0);
        @(posedge clk); #2;
        chk("lat_e1_valid", 96'(ov24), 96'd0);
        @(posedge clk); #2;
        chk("lat_e2_valid", 96'(ov24), 96'd1);
        chk("octo_hand_lane0", acc24, 96'd65025);
        chk("octo_hand_mode", 96'(om24), 96'd1);
        take_result();

        // 3. QUAD three back-to-back beats
        chk("quad_rdy_b1", 96'(rdy24), 96'd1);
        send(1'b0, 1'b0, 1, 2, 3, 4);
        chk("quad_rdy_b2", 96'(rdy24), 96'd1);
        send(1'b0, 1'b0, 10, 20, 30, 40);
        chk("quad_rdy_b3", 96'(rdy24), 96'd1);
        send(1'b0, 1'b1, 100, 110, 120, 225);
        chk("quad_rdy_flush", 96'(rdy24), 96'd0);
        wait_valid();
        chk("quad_rdy_hold", 96'(rdy24), 96'd0);
        chk("quad_hand_lanes", acc24, {24'd269, 24'd153, 24'd132, 24'd111});
        take_result();

        // 4. OCTO saturation in the 16-bit instance
        send(1'b1, 1'b0, 8'hE1, 8'hE1, 8'hE1, 8'hE1);
        send(1'b1, 1'b1, 8'hE1, 8'hE1, 8'hE1, 8'hE1);
        wait_valid();
        chk("sat16_hand_lane0", 96'(acc16), 96'd65535);
        chk("sat16_hand_ovf", 96'(ovf16), 96'b0001);
        chk("sat24_hand_lane0", acc24, 96'd130050);
        take_result();
        chk("ovf16_cleared", 96'(ovf16), 96'd0);
        chk("acc16_cleared", 96'(acc16), 96'd0);

        // 5. mode toggle mid-sequence is ignored
        send(1'b0, 1'b0, 5, 5, 5, 5);
        send(1'b1, 1'b1, 1, 1, 1, 1);
        wait_valid();
        chk("toggle_hand_lanes", acc24, {24'd6, 24'd6, 24'd6, 24'd6});
        chk("toggle_hand_mode", 96'(om24), 96'd0);
        take_result();

        // 6. hold under backpressure with in_valid asserted
        send(1'b0, 1'b1, 3, 3, 3, 3);
        in_valid = 1'b1; in_last = 1'b1; mode = 1'b0;
        pp0 = 8'd9; pp1 = 8'd9; pp2 = 8'd9; pp3 = 8'd9;
        for (int k = 0; k < 7; k++) begin
            @(posedge clk); #2;
            chk("hold_no_accept", 96'(rdy24), 96'd0);
        end
        chk("hold_valid", 96'(ov24), 96'd1);
        chk("hold_hand_lanes", acc24, {24'd3, 24'd3, 24'd3, 24'd3});
        in_valid = 1'b0; in_last = 1'b0;
        take_result();
        send(1'b0, 1'b1, 7, 8, 9, 10);
        wait_valid();
        chk("fresh_hand_lanes", acc24, {24'd10, 24'd9, 24'd8, 24'd7});
        take_result();

        // 1b. reset asserted in HOLD
        send(1'b0, 1'b1, 1, 1, 1, 1);
        wait_valid();
        #1 rst = 1'b1;
        #1;
        chk("rst_hold_valid", 96'(ov24), 96'd0);
        chk("rst_hold_acc", acc24, 96'd0);
        chk("rst_hold_ovf", 96'(ovf24), 96'd0);
        q.delete();
        @(posedge clk); #2 rst = 1'b0;
        chk("rst_release_ready", 96'(rdy24), 96'd1);
        send(1'b0, 1'b1, 2, 0, 0, 0);
        wait_valid();
        chk("post_rst_hand_lanes", acc24, 96'd2);
        take_result();

        repeat (3) @(posedge clk);
        #2;
        chk("queue_drained", 96'(q.size()), 96'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
